mem_access_stage: RTL and testbench

- MEM pipeline stage. Consumes the EX/MEM bundle: address in ALUres, store data in Bout, 7-bit cwMEM, Rdest, NPC+4.
- Runs a req/gnt/rvalid transaction to data memory and aligns load/store bytes.
- Stalls the pipeline while the access is outstanding, then loads the MEM/WB pipeline registers.

---
 rtl/mem_access_stage_if.sv | 35 +++
 rtl/mem_access_stage.sv | 270 +++++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// -----------------------------------------------------------------------------
// mem_access_stage_if
// Data-memory request/response bus between the MEM pipeline stage and the data
// memory. The stage uses the master modport and the memory uses the slave modport.
//   dmem_req    request valid (master -> slave)
//   dmem_we     1 = store, 0 = load
//   dmem_addr   word-aligned byte address
//   dmem_be     byte-lane enables
//   dmem_wdata  lane-replicated store data
//   dmem_gnt    request accepted (slave -> master)
//   dmem_rvalid load data valid; never in the same cycle as its gnt
//   dmem_rdata  load data word
// -----------------------------------------------------------------------------
interface mem_access_stage_if #(
    parameter int N = 32
);
    logic         dmem_req;
    logic         dmem_we;
    logic [N-1:0] dmem_addr;
    logic [3:0]   dmem_be;
    logic [N-1:0] dmem_wdata;
    logic         dmem_gnt;
    logic         dmem_rvalid;
    logic [N-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// MEM pipeline stage: issues a req/gnt/rvalid transaction for loads and stores,
// lines store data up on the byte lanes, extracts and extends load data, stalls
// the pipeline while the access is outstanding and loads the MEM/WB registers.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   pipe_en         global pipeline advance enable
//   ALUres, Bout    effective address, store data
//   cwMEM           [6]=rd [5]=wr [4:3]=size [2]=unsigned [1:0]=cwWB
//   Rdest_in, NPC4_IN  passed to MEM/WB
//   dmem            data-memory bus (master side)
//   mem_stall       hold IF..EX/MEM this cycle
//   MEMout, ALUres_out, NPC4_OUT, Rdest, cwWB, misalign, bus_err  MEM/WB registers
//
// Build option
//   MEM_TIMEOUT_EN  when defined, an access still outstanding after TIMEOUT_CYC
//                   wait cycles is abandoned and completes with bus_err=1.
//                   When undefined, the stage waits indefinitely and bus_err
//                   stays 0.
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int N           = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pipe_en,
    input  logic [N-1:0]       ALUres,
    input  logic [N-1:0]       Bout,
    input  logic [6:0]         cwMEM,
    input  logic [N-1:0]       Rdest_in,
    input  logic [N-1:0]       NPC4_IN,
    mem_access_stage_if.master dmem,
    output logic               mem_stall,
    output logic [N-1:0]       MEMout,
    output logic [N-1:0]       ALUres_out,
    output logic [N-1:0]       NPC4_OUT,
    output logic [N-1:0]       Rdest,
    output logic [1:0]         cwWB,
    output logic               misalign,
    output logic               bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'b00,
        ST_WAIT_GNT    = 2'b01,
        ST_WAIT_RVALID = 2'b10,
        ST_DONE        = 2'b11
    } state_t;

    state_t       state_r;
    logic [N-1:0] ld_buf_r;

    logic         mem_rd_s, mem_wr_s, uns_s, acc_s, misalign_s, acc_ok_s;
    logic [1:0]   size_s, off_s;
    logic         size_bad_s;
    logic [3:0]   be_s;
    logic [N-1:0] wdata_s;
    logic         req_s, done_s, stall_s, timeout_s, buf_err_s;
    logic [N-1:0] cpl_data_s;

    // Shift the addressed byte/half down to bit 0 and sign- or zero-extend it.
    function automatic logic [N-1:0] ld_extract(input logic [N-1:0] word,
                                                input logic [1:0]   off,
                                                input logic [1:0]   size,
                                                input logic         uns);
        logic [N-1:0] sh;
        logic [N-1:0] res;
        sh  = {N{1'b0}};
        res = {N{1'b0}};
        case (size)
            2'b00: begin
                sh  = word >> {off, 3'b000};
                res = uns ? {{(N-8){1'b0}}, sh[7:0]} : {{(N-8){sh[7]}}, sh[7:0]};
            end
            2'b01: begin
                sh  = word >> {off[1], 4'b0000};
                res = uns ? {{(N-16){1'b0}}, sh[15:0]} : {{(N-16){sh[15]}}, sh[15:0]};
            end
            2'b10:   res = word;
            default: res = {N{1'b0}};
        endcase
        return res;
    endfunction

    // Decode control word, alignment check and store lane placement.
    always_comb begin
        mem_rd_s = cwMEM[6];
        mem_wr_s = cwMEM[5];
        size_s   = cwMEM[4:3];
        uns_s    = cwMEM[2];
        off_s    = ALUres[1:0];
        acc_s    = mem_rd_s | mem_wr_s;
        case (size_s)
            2'b00: begin
                size_bad_s = 1'b0;
                be_s       = 4'b0001 << off_s;
                wdata_s    = {(N/8){Bout[7:0]}};
            end
            2'b01: begin
                size_bad_s = off_s[0];
                be_s       = 4'b0011 << off_s;
                wdata_s    = {(N/16){Bout[15:0]}};
            end
            2'b10: begin
                size_bad_s = (off_s != 2'b00);
                be_s       = 4'b1111;
                wdata_s    = Bout;
            end
            default: begin
                size_bad_s = 1'b1;
                be_s       = 4'b0000;
                wdata_s    = {N{1'b0}};
            end
        endcase
        // Simultaneous read and write is illegal and reported like a misalignment.
        misalign_s = acc_s & (size_bad_s | (mem_rd_s & mem_wr_s));
        acc_ok_s   = acc_s & ~misalign_s;
    end

    // Handshake: request, completion and stall for the current state.
    always_comb begin
        req_s      = 1'b0;
        done_s     = 1'b0;
        stall_s    = 1'b0;
        cpl_data_s = {N{1'b0}};
        if (rst) begin
            req_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (acc_ok_s) begin
                        req_s = 1'b1;
                        // A store completes on gnt; a load always waits for rvalid.
                        if (mem_wr_s && dmem.dmem_gnt) done_s = 1'b1;
                        else                           stall_s = 1'b1;
                    end else begin
                        req_s = 1'b0;
                    end
                end
                ST_WAIT_GNT: begin
                    if (timeout_s) begin
                        done_s = 1'b1;
                    end else begin
                        req_s = 1'b1;
                        if (mem_wr_s && dmem.dmem_gnt) done_s = 1'b1;
                        else                           stall_s = 1'b1;
                    end
                end
                ST_WAIT_RVALID: begin
                    if (dmem.dmem_rvalid) begin
                        done_s     = 1'b1;
                        cpl_data_s = ld_extract(dmem.dmem_rdata, off_s, size_s, uns_s);
                    end else if (timeout_s) begin
                        done_s = 1'b1;
                    end else begin
                        stall_s = 1'b1;
                    end
                end
                ST_DONE: begin
                    stall_s = 1'b0;
                end
                default: begin
                    stall_s = 1'b0;
                end
            endcase
        end
    end

    assign dmem.dmem_req   = req_s;
    assign dmem.dmem_we    = mem_wr_s;
    assign dmem.dmem_addr  = {ALUres[N-1:2], 2'b00};
    assign dmem.dmem_be    = be_s;
    assign dmem.dmem_wdata = wdata_s;
    assign mem_stall       = stall_s;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] to_cnt_r;
    logic             err_buf_r;
    logic             waiting_s;

    assign waiting_s = (state_r == ST_WAIT_GNT) || (state_r == ST_WAIT_RVALID);
    // Abort on the last allowed wait cycle unless the load data arrives in it.
    assign timeout_s = waiting_s && (to_cnt_r == CNT_W'(TIMEOUT_CYC - 1)) &&
                       !((state_r == ST_WAIT_RVALID) && dmem.dmem_rvalid);
    assign buf_err_s = err_buf_r;

    // Wait-cycle counter and the error flag held alongside the load buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_r  <= {CNT_W{1'b0}};
            err_buf_r <= 1'b0;
        end else begin
            if (waiting_s && !done_s) to_cnt_r <= to_cnt_r + CNT_W'(1);
            else                      to_cnt_r <= {CNT_W{1'b0}};
            if (done_s) err_buf_r <= timeout_s;
            else        err_buf_r <= err_buf_r;
        end
    end
`else
    // Without the watchdog the abort condition can never be true.
    assign timeout_s = (TIMEOUT_CYC < 0);
    assign buf_err_s = 1'b0;
`endif

    // Access FSM, load buffer and MEM/WB pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ld_buf_r   <= {N{1'b0}};
            MEMout     <= {N{1'b0}};
            ALUres_out <= {N{1'b0}};
            NPC4_OUT   <= {N{1'b0}};
            Rdest      <= {N{1'b0}};
            cwWB       <= 2'b00;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            if (done_s) begin
                state_r  <= pipe_en ? ST_IDLE : ST_DONE;
                ld_buf_r <= cpl_data_s;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        // Not complete here means a store without gnt or any load.
                        if (acc_ok_s) state_r <= dmem.dmem_gnt ? ST_WAIT_RVALID : ST_WAIT_GNT;
                        else          state_r <= ST_IDLE;
                    end
                    ST_WAIT_GNT: begin
                        if (dmem.dmem_gnt) state_r <= ST_WAIT_RVALID;
                        else               state_r <= ST_WAIT_GNT;
                    end
                    ST_WAIT_RVALID: state_r <= ST_WAIT_RVALID;
                    ST_DONE: begin
                        if (pipe_en) state_r <= ST_IDLE;
                        else         state_r <= ST_DONE;
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end

            if (pipe_en) begin
                if (stall_s) begin
                    cwWB     <= 2'b00;
                    misalign <= 1'b0;
                    bus_err  <= 1'b0;
                end else begin
                    ALUres_out <= ALUres;
                    NPC4_OUT   <= NPC4_IN;
                    Rdest      <= Rdest_in;
                    misalign   <= misalign_s;
                    if (state_r == ST_DONE) begin
                        MEMout  <= ld_buf_r;
                        bus_err <= buf_err_s;
                        cwWB    <= buf_err_s ? 2'b00 : cwMEM[1:0];
                    end else begin
                        MEMout  <= cpl_data_s;
                        bus_err <= timeout_s;
                        cwWB    <= (misalign_s | timeout_s) ? 2'b00 : cwMEM[1:0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
    localparam int N = 32;

    localparam logic [6:0] CW_LW   = 7'b1010001;
    localparam logic [6:0] CW_LB   = 7'b1000001;
    localparam logic [6:0] CW_LBU  = 7'b1000101;
    localparam logic [6:0] CW_LH   = 7'b1001001;
    localparam logic [6:0] CW_SH   = 7'b0101010;
    localparam logic [6:0] CW_SB   = 7'b0100010;
    localparam logic [6:0] CW_ALU  = 7'b0000001;
    localparam logic [6:0] CW_LILL = 7'b1011001;
    localparam logic [6:0] CW_RW   = 7'b1110001;

    logic         clk, rst, pipe_en, mem_stall, misalign, bus_err;
    logic [N-1:0] ALUres, Bout, Rdest_in, NPC4_IN;
    logic [N-1:0] MEMout, ALUres_out, NPC4_OUT, Rdest;
    logic [6:0]   cwMEM;
    logic [1:0]   cwWB;
    int           vec_cnt = 0;
    int           err_cnt = 0;

    mem_access_stage_if #(.N(N)) dmem_bus ();

    mem_access_stage #(.N(N), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst), .pipe_en(pipe_en), .ALUres(ALUres), .Bout(Bout),
        .cwMEM(cwMEM), .Rdest_in(Rdest_in), .NPC4_IN(NPC4_IN), .dmem(dmem_bus.master),
        .mem_stall(mem_stall), .MEMout(MEMout), .ALUres_out(ALUres_out),
        .NPC4_OUT(NPC4_OUT), .Rdest(Rdest), .cwWB(cwWB), .misalign(misalign),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] cw, input logic [N-1:0] a, input logic [N-1:0] b);
        cwMEM  = cw;
        ALUres = a;
        Bout   = b;
    endtask

    task automatic test_reset();
        rst = 1'b1; pipe_en = 1'b1;
        set_instr(CW_LW, 32'h0000_0100, 32'h0);
        Rdest_in = 32'd3; NPC4_IN = 32'h0000_1004;
        dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = 32'h0;
        tick(); tick();
        vec_cnt++; if (MEMout !== 32'h0) begin err_cnt++; $display("FAIL rst_memout: got %h want 0", MEMout); end
        vec_cnt++; if (ALUres_out !== 32'h0) begin err_cnt++; $display("FAIL rst_alures: got %h want 0", ALUres_out); end
        vec_cnt++; if (cwWB !== 2'b00) begin err_cnt++; $display("FAIL rst_cwwb: got %b want 00", cwWB); end
        vec_cnt++; if ({misalign, bus_err} !== 2'b00) begin err_cnt++; $display("FAIL rst_flags: got %b want 00", {misalign, bus_err}); end
        vec_cnt++; if (dmem_bus.dmem_req !== 1'b0) begin err_cnt++; $display("FAIL rst_req: got %b want 0", dmem_bus.dmem_req); end
        rst = 1'b0;
        set_instr(CW_ALU, 32'h0, 32'h0);
    endtask

    task automatic test_lw_zero_wait();
        set_instr(CW_ALU, 32'h0000_0040, 32'h0);
        tick();
        vec_cnt++; if (cwWB !== 2'b01) begin err_cnt++; $display("FAIL alu_cwwb: got %b want 01", cwWB); end
        set_instr(CW_LW, 32'h0000_0100, 32'h0);
        Rdest_in = 32'd5; NPC4_IN = 32'h0000_2004;
        dmem_bus.dmem_gnt = 1'b1;
        #1;
        vec_cnt++; if (dmem_bus.dmem_req !== 1'b1) begin err_cnt++; $display("FAIL lw_req_c0: got %b want 1", dmem_bus.dmem_req); end
        vec_cnt++; if (mem_stall !== 1'b1) begin err_cnt++; $display("FAIL lw_stall_c0: got %b want 1", mem_stall); end
        vec_cnt++; if ({dmem_bus.dmem_we, dmem_bus.dmem_be, dmem_bus.dmem_addr} !== {1'b0, 4'b1111, 32'h0000_0100}) begin
            err_cnt++; $display("FAIL lw_bus: got we=%b be=%b addr=%h want we=0 be=1111 addr=00000100", dmem_bus.dmem_we, dmem_bus.dmem_be, dmem_bus.dmem_addr); end
        tick();
        vec_cnt++; if (cwWB !== 2'b00) begin err_cnt++; $display("FAIL lw_bubble: got %b want 00", cwWB); end
        dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'hDEAD_BEEF;
        #1;
        vec_cnt++; if ({dmem_bus.dmem_req, mem_stall} !== 2'b00) begin err_cnt++; $display("FAIL lw_c1: got req,stall=%b want 00", {dmem_bus.dmem_req, mem_stall}); end
        tick();
        dmem_bus.dmem_rvalid = 1'b0;
        vec_cnt++; if (MEMout !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL lw_memout: got %h want deadbeef", MEMout); end
        vec_cnt++; if (cwWB !== 2'b01) begin err_cnt++; $display("FAIL lw_cwwb: got %b want 01", cwWB); end
        vec_cnt++; if ({ALUres_out, Rdest, NPC4_OUT} !== {32'h0000_0100, 32'd5, 32'h0000_2004}) begin
            err_cnt++; $display("FAIL lw_fields: got %h %h %h want 00000100 00000005 00002004", ALUres_out, Rdest, NPC4_OUT); end
        set_instr(CW_ALU, 32'h0, 32'h0);
    endtask

    task automatic test_sub_word_loads();
        logic [6:0]   cw_t [4] = '{CW_LB, CW_LBU, CW_LH, CW_LBU};
        logic [N-1:0] adr_t[4] = '{32'h103, 32'h103, 32'h102, 32'h101};
        logic [3:0]   be_t [4] = '{4'b1000, 4'b1000, 4'b1100, 4'b0010};
        logic [N-1:0] exp_t[4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8012, 32'h0000_0034};
        for (int i = 0; i < 4; i++) begin
            set_instr(cw_t[i], adr_t[i], 32'h0);
            dmem_bus.dmem_gnt = 1'b1;
            #1;
            vec_cnt++; if ({dmem_bus.dmem_be, dmem_bus.dmem_addr} !== {be_t[i], 32'h0000_0100}) begin
                err_cnt++; $display("FAIL ld%0d_bus: got be=%b addr=%h want be=%b addr=00000100", i, dmem_bus.dmem_be, dmem_bus.dmem_addr, be_t[i]); end
            tick();
            dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'h8012_3456;
            tick();
            dmem_bus.dmem_rvalid = 1'b0;
            vec_cnt++; if (MEMout !== exp_t[i]) begin err_cnt++; $display("FAIL ld%0d_memout: got %h want %h", i, MEMout, exp_t[i]); end
        end
        set_instr(CW_ALU, 32'h0, 32'h0);
    endtask

    task automatic test_store_delayed_gnt();
        set_instr(CW_SH, 32'h0000_0202, 32'h0000_ABCD);
        dmem_bus.dmem_gnt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            vec_cnt++; if ({dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_be, dmem_bus.dmem_addr, dmem_bus.dmem_wdata, mem_stall} !==
                           {1'b1, 1'b1, 4'b1100, 32'h0000_0200, 32'hABCD_ABCD, 1'b1}) begin
                err_cnt++; $display("FAIL sh_wait%0d: got req=%b we=%b be=%b addr=%h wd=%h stall=%b want 1 1 1100 00000200 abcdabcd 1",
                                    c, dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_be, dmem_bus.dmem_addr, dmem_bus.dmem_wdata, mem_stall); end
            tick();
            vec_cnt++; if (cwWB !== 2'b00) begin err_cnt++; $display("FAIL sh_bubble%0d: got %b want 00", c, cwWB); end
        end
        dmem_bus.dmem_gnt = 1'b1;
        #1;
        vec_cnt++; if ({dmem_bus.dmem_req, mem_stall} !== 2'b10) begin err_cnt++; $display("FAIL sh_gnt: got req,stall=%b want 10", {dmem_bus.dmem_req, mem_stall}); end
        tick();
        dmem_bus.dmem_gnt = 1'b0;
        vec_cnt++; if ({cwWB, ALUres_out, MEMout} !== {2'b10, 32'h0000_0202, 32'h0}) begin
            err_cnt++; $display("FAIL sh_done: got cwWB=%b alu=%h mem=%h want 10 00000202 00000000", cwWB, ALUres_out, MEMout); end
        set_instr(CW_SB, 32'h0000_0101, 32'h1234_565A);
        dmem_bus.dmem_gnt = 1'b1;
        #1;
        vec_cnt++; if ({dmem_bus.dmem_be, dmem_bus.dmem_wdata, mem_stall} !== {4'b0010, 32'h5A5A_5A5A, 1'b0}) begin
            err_cnt++; $display("FAIL sb_bus: got be=%b wd=%h stall=%b want 0010 5a5a5a5a 0", dmem_bus.dmem_be, dmem_bus.dmem_wdata, mem_stall); end
        tick();
        dmem_bus.dmem_gnt = 1'b0;
        vec_cnt++; if ({cwWB, ALUres_out} !== {2'b10, 32'h0000_0101}) begin err_cnt++; $display("FAIL sb_done: got %b %h want 10 00000101", cwWB, ALUres_out); end
        set_instr(CW_ALU, 32'h0, 32'h0);
    endtask

    task automatic test_misalign();
        logic [6:0]   cw_t [4] = '{CW_LW, CW_LH, CW_LILL, CW_RW};
        logic [N-1:0] adr_t[4] = '{32'h106, 32'h101, 32'h100, 32'h100};
        for (int i = 0; i < 4; i++) begin
            set_instr(cw_t[i], adr_t[i], 32'h0);
            dmem_bus.dmem_gnt = 1'b1;
            #1;
            vec_cnt++; if ({dmem_bus.dmem_req, mem_stall} !== 2'b00) begin err_cnt++; $display("FAIL mis%0d_req: got req,stall=%b want 00", i, {dmem_bus.dmem_req, mem_stall}); end
            tick();
            vec_cnt++; if ({misalign, cwWB} !== 3'b100) begin err_cnt++; $display("FAIL mis%0d_flag: got misalign,cwWB=%b want 100", i, {misalign, cwWB}); end
        end
        dmem_bus.dmem_gnt = 1'b0;
        set_instr(CW_ALU, 32'h0000_1234, 32'h0);
        Rdest_in = 32'd7; NPC4_IN = 32'h0000_2008;
        tick();
        vec_cnt++; if ({misalign, cwWB, MEMout, ALUres_out, Rdest} !== {1'b0, 2'b01, 32'h0, 32'h0000_1234, 32'd7}) begin
            err_cnt++; $display("FAIL alu_pass: got %b %b %h %h %h want 0 01 00000000 00001234 00000007", misalign, cwWB, MEMout, ALUres_out, Rdest); end
    endtask

    task automatic test_freeze();
        set_instr(CW_LW, 32'h0000_0104, 32'h0);
        Rdest_in = 32'd9;
        dmem_bus.dmem_gnt = 1'b1;
        tick();
        pipe_en = 1'b0; dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'h0000_0011;
        #1;
        vec_cnt++; if (mem_stall !== 1'b0) begin err_cnt++; $display("FAIL frz_stall: got %b want 0", mem_stall); end
        tick();
        vec_cnt++; if ({MEMout, ALUres_out, cwWB} !== {32'h0, 32'h0000_1234, 2'b00}) begin
            err_cnt++; $display("FAIL frz_hold: got %h %h %b want 00000000 00001234 00", MEMout, ALUres_out, cwWB); end
        dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = 32'h0000_00FF;
        #1;
        vec_cnt++; if ({dmem_bus.dmem_req, mem_stall} !== 2'b00) begin err_cnt++; $display("FAIL frz_done: got req,stall=%b want 00", {dmem_bus.dmem_req, mem_stall}); end
        tick();
        vec_cnt++; if (MEMout !== 32'h0) begin err_cnt++; $display("FAIL frz_hold2: got %h want 0", MEMout); end
        pipe_en = 1'b1;
        tick();
        vec_cnt++; if ({MEMout, cwWB, ALUres_out, Rdest} !== {32'h0000_0011, 2'b01, 32'h0000_0104, 32'd9}) begin
            err_cnt++; $display("FAIL frz_release: got %h %b %h %h want 00000011 01 00000104 00000009", MEMout, cwWB, ALUres_out, Rdest); end
        set_instr(CW_ALU, 32'h0, 32'h0);
    endtask

    task automatic test_reset_mid();
        set_instr(CW_LW, 32'h0000_0108, 32'h0);
        dmem_bus.dmem_gnt = 1'b1;
        tick();
        rst = 1'b1; dmem_bus.dmem_gnt = 1'b0;
        tick();
        vec_cnt++; if ({MEMout, ALUres_out, NPC4_OUT, Rdest, cwWB, misalign, bus_err, dmem_bus.dmem_req} !== {{4{32'h0}}, 5'b00000}) begin
            err_cnt++; $display("FAIL rstmid_zero: got %h %h %h %h %b %b %b %b want all 0", MEMout, ALUres_out, NPC4_OUT, Rdest, cwWB, misalign, bus_err, dmem_bus.dmem_req); end
        rst = 1'b0;
        #1;
        vec_cnt++; if ({dmem_bus.dmem_req, mem_stall} !== 2'b11) begin err_cnt++; $display("FAIL rstmid_idle: got req,stall=%b want 11", {dmem_bus.dmem_req, mem_stall}); end
        dmem_bus.dmem_gnt = 1'b1;
        tick();
        dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'hCAFE_F00D;
        tick();
        dmem_bus.dmem_rvalid = 1'b0;
        vec_cnt++; if ({MEMout, cwWB} !== {32'hCAFE_F00D, 2'b01}) begin err_cnt++; $display("FAIL rstmid_ld: got %h %b want cafef00d 01", MEMout, cwWB); end
        set_instr(CW_ALU, 32'h0, 32'h0);
    endtask

    task automatic test_timeout();
        set_instr(CW_LW, 32'h0000_010C, 32'h0);
        dmem_bus.dmem_gnt = 1'b0;
`ifdef MEM_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            #1;
            vec_cnt++; if ({dmem_bus.dmem_req, mem_stall} !== 2'b11) begin err_cnt++; $display("FAIL to_wait%0d: got req,stall=%b want 11", c, {dmem_bus.dmem_req, mem_stall}); end
            tick();
        end
        #1;
        vec_cnt++; if ({dmem_bus.dmem_req, mem_stall} !== 2'b00) begin err_cnt++; $display("FAIL to_abort: got req,stall=%b want 00", {dmem_bus.dmem_req, mem_stall}); end
        tick();
        vec_cnt++; if ({bus_err, cwWB, MEMout} !== {1'b1, 2'b00, 32'h0}) begin
            err_cnt++; $display("FAIL to_result: got %b %b %h want 1 00 00000000", bus_err, cwWB, MEMout); end
        set_instr(CW_ALU, 32'h0, 32'h0);
        tick();
        vec_cnt++; if ({bus_err, cwWB} !== 3'b001) begin err_cnt++; $display("FAIL to_next: got %b want 001", {bus_err, cwWB}); end
`else
        for (int c = 0; c < 8; c++) begin
            #1;
            vec_cnt++; if ({dmem_bus.dmem_req, mem_stall} !== 2'b11) begin err_cnt++; $display("FAIL nto_wait%0d: got req,stall=%b want 11", c, {dmem_bus.dmem_req, mem_stall}); end
            tick();
        end
        dmem_bus.dmem_gnt = 1'b1;
        tick();
        dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'h0BAD_CAFE;
        tick();
        dmem_bus.dmem_rvalid = 1'b0;
        vec_cnt++; if ({MEMout, bus_err, cwWB} !== {32'h0BAD_CAFE, 1'b0, 2'b01}) begin
            err_cnt++; $display("FAIL nto_done: got %h %b %b want 0badcafe 0 01", MEMout, bus_err, cwWB); end
        set_instr(CW_ALU, 32'h0, 32'h0);
`endif
    endtask

    initial begin
        test_reset();
        test_lw_zero_wait();
        test_sub_word_loads();
        test_store_delayed_gnt();
        test_misalign();
        test_freeze();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
